// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory responder: size encodings,
// FSM state type, default timing/geometry, and the alignment rule.
package dm_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  localparam int DEF_LATENCY = 2;
  localparam int DEF_DEPTH   = 1024;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } state_t;

  // A request is rejected when its size is reserved or its address is not
  // naturally aligned to that size.
  function automatic logic access_error(input logic [1:0] size, input logic [1:0] addr_lo);
    logic err;
    case (size)
      SZ_BYTE: err = 1'b0;
      SZ_HALF: err = addr_lo[0];
      SZ_WORD: err = (addr_lo != 2'b00);
      default: err = 1'b1;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/dm_lane.sv
// Byte-lane steering for one access: merges store data into the old word,
// extracts and extends load data, and flags misaligned/reserved requests.
module dm_lane
  import dm_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic        sign,
  input  logic [31:0] wdata,
  input  logic [31:0] old_word,
  output logic [31:0] wr_word,
  output logic [31:0] rd_data,
  output logic        err
);

  logic [7:0]  ld_byte_s;
  logic [15:0] ld_half_s;
  logic [31:0] rd_raw_s;
  logic [4:0]  bit_ofs_s;

  // Select the addressed byte and half lanes of the old word (little-endian).
  always_comb begin
    bit_ofs_s = {addr_lo, 3'b000};
    ld_byte_s = old_word[bit_ofs_s +: 8];
    if (addr_lo[1]) begin
      ld_half_s = old_word[31:16];
    end else begin
      ld_half_s = old_word[15:0];
    end
  end

  // Build the merged store word and the extended load value for the size.
  always_comb begin
    wr_word  = old_word;
    rd_raw_s = 32'h0000_0000;
    case (size)
      SZ_BYTE: begin
        wr_word[bit_ofs_s +: 8] = wdata[7:0];
        if (sign) begin
          rd_raw_s = {{24{ld_byte_s[7]}}, ld_byte_s};
        end else begin
          rd_raw_s = {24'h00_0000, ld_byte_s};
        end
      end
      SZ_HALF: begin
        if (addr_lo[1]) begin
          wr_word[31:16] = wdata[15:0];
        end else begin
          wr_word[15:0] = wdata[15:0];
        end
        if (sign) begin
          rd_raw_s = {{16{ld_half_s[15]}}, ld_half_s};
        end else begin
          rd_raw_s = {16'h0000, ld_half_s};
        end
      end
      SZ_WORD: begin
        wr_word  = wdata;
        rd_raw_s = old_word;
      end
      default: begin
        wr_word  = old_word;
        rd_raw_s = 32'h0000_0000;
      end
    endcase
  end

  // Errors suppress load data so a faulting access never returns memory.
  always_comb begin
    err = access_error(size, addr_lo);
    if (err) begin
      rd_data = 32'h0000_0000;
    end else begin
      rd_data = rd_raw_s;
    end
  end

endmodule

// File: rtl/dm_responder.sv
// Target-side data memory with configurable latency: accepts one request
// at a time, performs the access when the latency expires, and holds the
// response until the initiator takes it.
module dm_responder
  import dm_pkg::*;
#(
  parameter int LATENCY = DEF_LATENCY,
  parameter int DEPTH   = DEF_DEPTH
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_sign,
  input  logic [11:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (LATENCY > 2) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  state_t        state_r;
  logic [CW-1:0] cnt_r;
  logic          we_r;
  logic [1:0]    size_r;
  logic          sign_r;
  logic [11:0]   addr_r;
  logic [31:0]   wdata_r;
  logic [31:0]   pc_r;
  logic          req_ready_r;
  logic          resp_valid_r;
  logic [31:0]   resp_rdata_r;
  logic          resp_err_r;
  logic [31:0]   mem_r [DEPTH];

  logic          op_we_s;
  logic [1:0]    op_size_s;
  logic          op_sign_s;
  logic [11:0]   op_addr_s;
  logic [31:0]   op_wdata_s;
  logic [31:0]   op_pc_s;
  logic [AW-1:0] op_idx_s;
  logic [31:0]   old_word_s;
  logic          access_s;
  logic          wr_en_s;
  logic [31:0]   lane_wr_s;
  logic [31:0]   lane_rd_s;
  logic          lane_err_s;
  logic [31:0]   resp_data_s;

  // Write-log tap: the committing store's PC, word address and resulting word.
  logic [31:0]   log_pc_s;
  logic [11:0]   log_addr_s;
  logic [31:0]   log_word_s;
  logic          log_unused_s;

  assign req_ready  = req_ready_r;
  assign resp_valid = resp_valid_r;
  assign resp_rdata = resp_rdata_r;
  assign resp_err   = resp_err_r;

  // Access operands: live request when committing straight from IDLE, else the latched copy.
  always_comb begin
    if (state_r == ST_IDLE) begin
      op_we_s    = req_we;
      op_size_s  = req_size;
      op_sign_s  = req_sign;
      op_addr_s  = req_addr;
      op_wdata_s = req_wdata;
      op_pc_s    = req_pc;
    end else begin
      op_we_s    = we_r;
      op_size_s  = size_r;
      op_sign_s  = sign_r;
      op_addr_s  = addr_r;
      op_wdata_s = wdata_r;
      op_pc_s    = pc_r;
    end
  end

  // The access happens exactly once, on the edge that enters RESP.
  always_comb begin
    case (state_r)
      ST_IDLE: access_s = (LATENCY == 1) && req_valid;
      ST_WAIT: access_s = (cnt_r == CNT_ZERO);
      default: access_s = 1'b0;
    endcase
  end

  assign op_idx_s    = op_addr_s[AW+1:2];
  assign old_word_s  = mem_r[op_idx_s];
  assign wr_en_s     = reset && access_s && op_we_s && !lane_err_s;
  assign resp_data_s = op_we_s ? 32'h0000_0000 : lane_rd_s;

  assign log_pc_s     = op_pc_s;
  assign log_addr_s   = {op_addr_s[11:2], 2'b00};
  assign log_word_s   = lane_wr_s;
  assign log_unused_s = ^{log_pc_s, log_addr_s, log_word_s};

  dm_lane u_lane (
    .size     (op_size_s),
    .addr_lo  (op_addr_s[1:0]),
    .sign     (op_sign_s),
    .wdata    (op_wdata_s),
    .old_word (old_word_s),
    .wr_word  (lane_wr_s),
    .rd_data  (lane_rd_s),
    .err      (lane_err_s)
  );

  // Storage: cleared by reset, written only by a committing, error-free store.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 32'h0000_0000;
      end
    end else if (wr_en_s) begin
      mem_r[op_idx_s] <= lane_wr_s;
    end
  end

  // Request/response FSM with latency counter and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r      <= ST_IDLE;
      cnt_r        <= CNT_ZERO;
      we_r         <= 1'b0;
      size_r       <= SZ_BYTE;
      sign_r       <= 1'b0;
      addr_r       <= 12'h000;
      wdata_r      <= 32'h0000_0000;
      pc_r         <= 32'h0000_0000;
      req_ready_r  <= 1'b1;
      resp_valid_r <= 1'b0;
      resp_rdata_r <= 32'h0000_0000;
      resp_err_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (req_valid) begin
            we_r        <= req_we;
            size_r      <= req_size;
            sign_r      <= req_sign;
            addr_r      <= req_addr;
            wdata_r     <= req_wdata;
            pc_r        <= req_pc;
            cnt_r       <= CNT_LOAD;
            req_ready_r <= 1'b0;
            if (LATENCY == 1) begin
              state_r      <= ST_RESP;
              resp_valid_r <= 1'b1;
              resp_rdata_r <= resp_data_s;
              resp_err_r   <= lane_err_s;
            end else begin
              state_r <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (cnt_r == CNT_ZERO) begin
            state_r      <= ST_RESP;
            resp_valid_r <= 1'b1;
            resp_rdata_r <= resp_data_s;
            resp_err_r   <= lane_err_s;
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end
        ST_RESP: begin
          if (resp_ready) begin
            state_r      <= ST_IDLE;
            req_ready_r  <= 1'b1;
            resp_valid_r <= 1'b0;
            resp_rdata_r <= 32'h0000_0000;
            resp_err_r   <= 1'b0;
          end
        end
        default: begin
          state_r      <= ST_IDLE;
          req_ready_r  <= 1'b1;
          resp_valid_r <= 1'b0;
          resp_rdata_r <= 32'h0000_0000;
          resp_err_r   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dm_responder.sv
// Scoreboard bench for dm_responder: stimulus pushes expected responses,
// a monitor compares them (data, error, latency, stability) as they appear.
module tb_dm_responder;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_sign;
  logic [11:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] req_pc;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   log_count = 0;
  bit   in_resp = 1'b0;

  dm_responder #(.LATENCY(LAT), .DEPTH(1024)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_sign   (req_sign),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_pc     (req_pc),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Write log: one line per committed store.
  always @(posedge clk) begin
    if (dut.wr_en_s) begin
      $display("@%h: *%h <= %h", dut.log_pc_s, dut.log_addr_s, dut.log_word_s);
      log_count++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: compare every cycle a response is presented against the queue head.
  always @(negedge clk) begin
    if (reset === 1'b1 && resp_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp: got rdata %h err %b with no request pending", resp_rdata, resp_err);
      end else begin
        if (!in_resp) begin
          in_resp = 1'b1;
          check("latency", 32'(cyc - sb_q[0].acc), 32'(LAT));
        end
        check("rdata", resp_rdata, sb_q[0].rdata);
        check("err", {31'b0, resp_err}, {31'b0, sb_q[0].err});
        check("req_ready_in_resp", {31'b0, req_ready}, 32'h0);
        if (resp_ready) begin
          void'(sb_q.pop_front());
          in_resp = 1'b0;
        end
      end
    end
  end

  task automatic issue(input logic we, input logic [1:0] size, input logic sign,
                       input logic [11:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input logic exp_err);
    int t;
    exp_t e;
    t = 0;
    @(negedge clk);
    while (!req_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!req_ready) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout: got req_ready %b expected 1", req_ready);
      return;
    end
    req_we    = we;
    req_size  = size;
    req_sign  = sign;
    req_addr  = addr;
    req_wdata = wdata;
    req_pc    = 32'h0040_0000 + {20'h0, addr};
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    e.rdata = exp_rdata;
    e.err   = exp_err;
    e.acc   = cyc;
    sb_q.push_back(e);
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb_q.size() != 0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb_q.size());
      sb_q.delete();
      in_resp = 1'b0;
    end
  endtask

  initial begin
    int t;
    reset      = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_size   = 2'b00;
    req_sign   = 1'b0;
    req_addr   = 12'h000;
    req_wdata  = 32'h0;
    req_pc     = 32'h0;
    resp_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", {31'b0, req_ready}, 32'h1);
    check("rst_resp_valid", {31'b0, resp_valid}, 32'h0);
    check("rst_rdata", resp_rdata, 32'h0);
    check("rst_err", {31'b0, resp_err}, 32'h0);
    reset = 1'b1;

    // Word store/load round trip.
    issue(1'b1, 2'b10, 1'b0, 12'h010, 32'h1234_5678, 32'h0, 1'b0);
    issue(1'b0, 2'b10, 1'b0, 12'h010, 32'h0, 32'h1234_5678, 1'b0);
    // Byte store to lane 3, word and half reads.
    issue(1'b1, 2'b00, 1'b0, 12'h003, 32'h0000_00AB, 32'h0, 1'b0);
    issue(1'b0, 2'b10, 1'b0, 12'h000, 32'h0, 32'hAB00_0000, 1'b0);
    issue(1'b0, 2'b01, 1'b0, 12'h002, 32'h0, 32'h0000_AB00, 1'b0);
    issue(1'b0, 2'b01, 1'b1, 12'h002, 32'h0, 32'hFFFF_AB00, 1'b0);
    // Byte sign/zero extension.
    issue(1'b1, 2'b00, 1'b0, 12'h020, 32'h0000_0080, 32'h0, 1'b0);
    issue(1'b0, 2'b00, 1'b1, 12'h020, 32'h0, 32'hFFFF_FF80, 1'b0);
    issue(1'b0, 2'b00, 1'b0, 12'h020, 32'h0, 32'h0000_0080, 1'b0);
    // Upper-half store merges into the existing word.
    issue(1'b1, 2'b01, 1'b0, 12'h012, 32'h0000_CAFE, 32'h0, 1'b0);
    issue(1'b0, 2'b10, 1'b0, 12'h010, 32'h0, 32'hCAFE_5678, 1'b0);
    issue(1'b0, 2'b01, 1'b1, 12'h012, 32'h0, 32'hFFFF_CAFE, 1'b0);
    issue(1'b0, 2'b00, 1'b0, 12'h011, 32'h0, 32'h0000_0056, 1'b0);
    // Misaligned and reserved-size requests.
    issue(1'b0, 2'b10, 1'b0, 12'h002, 32'h0, 32'h0, 1'b1);
    issue(1'b1, 2'b01, 1'b0, 12'h005, 32'h0000_BEEF, 32'h0, 1'b1);
    issue(1'b0, 2'b11, 1'b0, 12'h008, 32'h0, 32'h0, 1'b1);
    issue(1'b0, 2'b10, 1'b0, 12'h004, 32'h0, 32'h0, 1'b0);
    drain();
    check("log_count_after_errors", 32'(log_count), 32'd4);

    // Back-pressure: hold the response, offer an ignored store meanwhile.
    resp_ready = 1'b0;
    issue(1'b0, 2'b10, 1'b0, 12'h010, 32'h0, 32'hCAFE_5678, 1'b0);
    t = 0;
    while (!resp_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("hold_resp_seen", {31'b0, resp_valid}, 32'h1);
    @(posedge clk);
    #1;
    req_we    = 1'b1;
    req_size  = 2'b10;
    req_addr  = 12'h010;
    req_wdata = 32'hFFFF_FFFF;
    req_valid = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    resp_ready = 1'b1;
    req_valid  = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("idle_after_release", {31'b0, req_ready}, 32'h1);
    check("valid_low_after_release", {31'b0, resp_valid}, 32'h0);
    drain();
    issue(1'b0, 2'b10, 1'b0, 12'h010, 32'h0, 32'hCAFE_5678, 1'b0);
    drain();

    // Reset during WAIT of a store: nothing committed, memory cleared.
    @(negedge clk);
    req_we    = 1'b1;
    req_size  = 2'b10;
    req_sign  = 1'b0;
    req_addr  = 12'h040;
    req_wdata = 32'hDEAD_BEEF;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midrst_req_ready", {31'b0, req_ready}, 32'h1);
    check("midrst_resp_valid", {31'b0, resp_valid}, 32'h0);
    check("midrst_rdata", resp_rdata, 32'h0);
    check("midrst_err", {31'b0, resp_err}, 32'h0);
    reset = 1'b1;
    issue(1'b0, 2'b10, 1'b0, 12'h040, 32'h0, 32'h0, 1'b0);
    issue(1'b0, 2'b10, 1'b0, 12'h010, 32'h0, 32'h0, 1'b0);
    drain();
    check("log_count_final", 32'(log_count), 32'd4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
